// File: rtl/vga_logo_pkg.sv
// Shared VGA logo definitions: coordinate width and the scroll controller state encoding.
package vga_logo_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE_R  = 3'd1,
    DWELL_R = 3'd2,
    MOVE_L  = 3'd3,
    DWELL_L = 3'd4
  } state_t;

endpackage

// File: rtl/vga_edge_detect.sv
// Registered vsync active-edge detector; emits a one-cycle pulse the cycle after the edge is sampled.
module vga_edge_detect #(
  parameter bit ACT_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic sig_q_r;
  logic edge_s;

  // Active edge of the incoming level, polarity selected at build time
  always_comb begin
    edge_s = ACT_LOW ? (sig_q_r & ~sig) : (~sig_q_r & sig);
  end

  // Delay register and registered pulse; delay resets to the inactive level
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q_r <= ACT_LOW;
      pulse   <= 1'b0;
    end else begin
      sig_q_r <= sig;
      pulse   <= edge_s;
    end
  end

endmodule

// File: rtl/logo_scroll_ctrl.sv
// Frame-synchronous ping-pong horizontal offset for the VGA logo painters.
// Optional endpoint dwell states are enabled by defining LOGO_SCROLL_DWELL_EN.
module logo_scroll_ctrl
  import vga_logo_pkg::*;
#(
  parameter int DELT_MAX        = 200,
  parameter int STEP            = 4,
  parameter int FRAMES_PER_STEP = 2,
  parameter int DWELL_FRAMES    = 30,
  parameter int VSYNC_ACT_LOW   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               vsync,
  output logic [COORD_W-1:0] delt,
  output logic               dir,
  output logic               frame_tick,
  output logic               moving
);

  // One width serves both the step and dwell counters
  localparam int CNT_MAX = (FRAMES_PER_STEP > DWELL_FRAMES) ? FRAMES_PER_STEP : DWELL_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   FCNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(1'b0);
  localparam logic [11:0]        STEP12    = 12'(STEP);
  localparam logic [11:0]        MAX12     = 12'(DELT_MAX);
  localparam logic [COORD_W-1:0] MAX_C     = COORD_W'(DELT_MAX);
  localparam logic [COORD_W-1:0] ZERO_C    = {COORD_W{1'b0}};

  state_t           state_r;
  logic [CNT_W-1:0] frame_cnt_r;
`ifdef LOGO_SCROLL_DWELL_EN
  localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DWELL_FRAMES - 1);
  logic [CNT_W-1:0] dwell_cnt_r;
`endif

  logic [11:0]        delt12_s;
  logic [11:0]        sum_s;
  logic               right_end_s;
  logic               left_end_s;
  logic [COORD_W-1:0] right_next_s;
  logic [COORD_W-1:0] left_next_s;
  logic               step_due_s;
  logic               tick_go_s;

  vga_edge_detect #(
    .ACT_LOW (VSYNC_ACT_LOW != 0)
  ) u_edge (
    .clk   (clk),
    .rst   (rst),
    .sig   (vsync),
    .pulse (frame_tick)
  );

  // Saturating step candidates in 12 bits so the offset can never wrap
  always_comb begin
    delt12_s     = {1'b0, delt};
    sum_s        = delt12_s + STEP12;
    right_end_s  = (sum_s >= MAX12);
    left_end_s   = (delt12_s <= STEP12);
    right_next_s = right_end_s ? MAX_C : sum_s[COORD_W-1:0];
    left_next_s  = left_end_s ? ZERO_C : COORD_W'(delt12_s - STEP12);
    step_due_s   = (frame_cnt_r == FCNT_LAST);
    tick_go_s    = frame_tick & en;
  end

  // Scroll FSM; everything advances only on the edge closing an enabled frame_tick cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      frame_cnt_r <= CNT_ZERO;
`ifdef LOGO_SCROLL_DWELL_EN
      dwell_cnt_r <= CNT_ZERO;
`endif
      delt        <= ZERO_C;
      dir         <= 1'b0;
      moving      <= 1'b0;
    end else if (tick_go_s) begin
      case (state_r)
        IDLE: begin
          state_r     <= MOVE_R;
          frame_cnt_r <= CNT_ZERO;
          moving      <= 1'b1;
        end
        MOVE_R: begin
          if (step_due_s) begin
            frame_cnt_r <= CNT_ZERO;
            delt        <= right_next_s;
            if (right_end_s) begin
`ifdef LOGO_SCROLL_DWELL_EN
              state_r     <= DWELL_R;
              dwell_cnt_r <= CNT_ZERO;
              moving      <= 1'b0;
`else
              state_r     <= MOVE_L;
              dir         <= 1'b1;
`endif
            end
          end else begin
            frame_cnt_r <= frame_cnt_r + CNT_ONE;
          end
        end
        MOVE_L: begin
          if (step_due_s) begin
            frame_cnt_r <= CNT_ZERO;
            delt        <= left_next_s;
            if (left_end_s) begin
`ifdef LOGO_SCROLL_DWELL_EN
              state_r     <= DWELL_L;
              dwell_cnt_r <= CNT_ZERO;
              moving      <= 1'b0;
`else
              state_r     <= MOVE_R;
              dir         <= 1'b0;
`endif
            end
          end else begin
            frame_cnt_r <= frame_cnt_r + CNT_ONE;
          end
        end
`ifdef LOGO_SCROLL_DWELL_EN
        DWELL_R: begin
          if (dwell_cnt_r == DCNT_LAST) begin
            state_r     <= MOVE_L;
            dir         <= 1'b1;
            moving      <= 1'b1;
            dwell_cnt_r <= CNT_ZERO;
            frame_cnt_r <= CNT_ZERO;
          end else begin
            dwell_cnt_r <= dwell_cnt_r + CNT_ONE;
          end
        end
        DWELL_L: begin
          if (dwell_cnt_r == DCNT_LAST) begin
            state_r     <= MOVE_R;
            dir         <= 1'b0;
            moving      <= 1'b1;
            dwell_cnt_r <= CNT_ZERO;
            frame_cnt_r <= CNT_ZERO;
          end else begin
            dwell_cnt_r <= dwell_cnt_r + CNT_ONE;
          end
        end
`endif
        default: begin
          // Unreachable encodings recover to a clean idle
          state_r     <= IDLE;
          frame_cnt_r <= CNT_ZERO;
          moving      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logo_scroll_ctrl.sv
// Scoreboard bench for logo_scroll_ctrl: two instances (FRAMES_PER_STEP 1 and 3) against a frame-level model.
module tb_logo_scroll_ctrl;

  localparam int DMAX  = 10;
  localparam int STP   = 4;
  localparam int DWELL = 3;

  typedef struct {
    int cyc;
    int delt;
    int dir;
    int mov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, en, vsync;
  logic [10:0] delt_a, delt_b;
  logic        dir_a, dir_b, tick_a, tick_b, mov_a, mov_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   issued = 0;
  int   seen [2] = '{0, 0};
  exp_t q0 [$];
  exp_t q1 [$];

  int m_pos [2], m_dir [2], m_mode [2], m_fc [2], m_dc [2];
  int fps [2] = '{1, 3};

  logo_scroll_ctrl #(.DELT_MAX(DMAX), .STEP(STP), .FRAMES_PER_STEP(1),
                     .DWELL_FRAMES(DWELL), .VSYNC_ACT_LOW(1)) dut_a (
    .clk(clk), .rst(rst_a), .en(en), .vsync(vsync),
    .delt(delt_a), .dir(dir_a), .frame_tick(tick_a), .moving(mov_a));

  logo_scroll_ctrl #(.DELT_MAX(DMAX), .STEP(STP), .FRAMES_PER_STEP(3),
                     .DWELL_FRAMES(DWELL), .VSYNC_ACT_LOW(1)) dut_b (
    .clk(clk), .rst(rst_b), .en(en), .vsync(vsync),
    .delt(delt_b), .dir(dir_b), .frame_tick(tick_b), .moving(mov_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame-level reference: mode 0 idle, 1 moving, 2 resting at an endpoint
  task automatic model_reset(input int id);
    m_pos[id] = 0; m_dir[id] = 0; m_mode[id] = 0; m_fc[id] = 0; m_dc[id] = 0;
  endtask

  task automatic model_tick(input int id);
    bit hit;
    if (!en) return;
    case (m_mode[id])
      0: begin m_mode[id] = 1; m_fc[id] = 0; end
      1: begin
        m_fc[id]++;
        if (m_fc[id] == fps[id]) begin
          m_fc[id] = 0;
          hit = 1'b0;
          if (m_dir[id] == 0) begin
            if (m_pos[id] + STP >= DMAX) begin m_pos[id] = DMAX; hit = 1'b1; end
            else m_pos[id] += STP;
          end else begin
            if (m_pos[id] <= STP) begin m_pos[id] = 0; hit = 1'b1; end
            else m_pos[id] -= STP;
          end
          if (hit) begin
`ifdef LOGO_SCROLL_DWELL_EN
            m_mode[id] = 2; m_dc[id] = 0;
`else
            m_dir[id] ^= 1;
`endif
          end
        end
      end
      2: begin
        m_dc[id]++;
        if (m_dc[id] == DWELL) begin
          m_mode[id] = 1; m_dir[id] ^= 1; m_dc[id] = 0; m_fc[id] = 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic exp_t snap(input int id, input int c);
    exp_t e;
    e.cyc = c; e.delt = m_pos[id]; e.dir = m_dir[id]; e.mov = (m_mode[id] == 1) ? 1 : 0;
    return e;
  endfunction

  // One vsync low pulse; rst_hit asserts dut_b reset exactly in its frame_tick cycle
  task automatic issue_tick(input int low_len, input bit rst_hit, input int gap);
    int c;
    int ll;
    ll = rst_hit ? 1 : low_len;
    @(posedge clk); #1;
    vsync = 1'b0;
    c = cyc;
    model_tick(0);
    q0.push_back(snap(0, c + 1));
    if (rst_hit) model_reset(1);
    else model_tick(1);
    q1.push_back(snap(1, c + 1));
    issued++;
    @(posedge clk); #1;
    if (rst_hit) rst_b = 1'b1;
    for (int i = 1; i < ll; i++) begin @(posedge clk); #1; end
    vsync = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic monitor(input int id);
    exp_t  e;
    string p;
    p = (id == 0) ? "a_" : "b_";
    forever begin
      @(negedge clk);
      if ((id == 0) ? tick_a : tick_b) begin
        seen[id]++;
        if (((id == 0) ? q0.size() : q1.size()) == 0) begin
          chk({p, "unexpected_tick"}, 1, 0);
        end else begin
          if (id == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk({p, "tick_cycle"}, cyc, e.cyc);
          @(negedge clk);
          chk({p, "delt"},   (id == 0) ? int'(delt_a) : int'(delt_b), e.delt);
          chk({p, "dir"},    (id == 0) ? int'(dir_a)  : int'(dir_b),  e.dir);
          chk({p, "moving"}, (id == 0) ? int'(mov_a)  : int'(mov_b),  e.mov);
          chk({p, "tick_width"}, (id == 0) ? int'(tick_a) : int'(tick_b), 0);
          chk({p, "delt_in_range"}, (((id == 0) ? int'(delt_a) : int'(delt_b)) <= DMAX) ? 1 : 0, 1);
        end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    model_reset(0);
    model_reset(1);
    rst_a = 1'b1; rst_b = 1'b1; en = 1'b1; vsync = 1'b1;
    fork
      monitor(0);
      monitor(1);
    join_none

    // Reset held three cycles while vsync toggles
    repeat (3) begin
      @(posedge clk); #1;
      vsync = ~vsync;
      @(negedge clk);
      chk("rst_delt_a", int'(delt_a), 0);
      chk("rst_delt_b", int'(delt_b), 0);
      chk("rst_dir_a",  int'(dir_a),  0);
      chk("rst_mov_a",  int'(mov_a),  0);
      chk("rst_tick_a", int'(tick_a), 0);
      chk("rst_tick_b", int'(tick_b), 0);
    end
    vsync = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(posedge clk);

    // Full out-and-back sweep for the single-frame instance
    repeat (16) issue_tick($urandom_range(1, 3), 1'b0, $urandom_range(2, 6));

    // Advance to delt=8 heading right, then freeze for five frames
    n = 0;
    while (!(m_pos[0] == 8 && m_dir[0] == 0 && m_mode[0] == 1) && n < 60) begin
      issue_tick($urandom_range(1, 3), 1'b0, $urandom_range(2, 6));
      n++;
    end
    chk("reach_freeze_point_within_bound", (n < 60) ? 1 : 0, 1);
    en = 1'b0;
    repeat (5) issue_tick($urandom_range(1, 3), 1'b0, $urandom_range(2, 6));
    en = 1'b1;
    issue_tick(1, 1'b0, 3);

    // Partial sweep on the 3-frame instance, then reset coincident with a tick
    repeat (4) issue_tick($urandom_range(1, 3), 1'b0, $urandom_range(2, 6));
    issue_tick(1, 1'b1, 4);

    // Random enable pattern
    repeat (40) begin
      en = ($urandom_range(0, 3) != 0);
      issue_tick($urandom_range(1, 3), 1'b0, $urandom_range(2, 8));
    end
    en = 1'b1;

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk("queues_drained", q0.size() + q1.size(), 0);
    chk("a_tick_count", seen[0], issued);
    chk("b_tick_count", seen[1], issued);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
